regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-issue 2R1W register file.
- Configurable data width, register count and read-port count.
- Two write ports with defined priority.
- Per-register scoreboard (pending-write) bits for pipelined or dual-issue cores.
- Sequential sweep-clear engine for context flush without a global reset.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers (power of 2, >=2).
- NRD, 2, number of read ports (1..8).
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes, scoreboard sets and clear-sweep writes to it are ignored; reads return 0).
- AW, $clog2(NREG), address width (derived, not overridden).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_rs_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
- o_rs_data  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]; combinational.
- o_rs_busy  out  NRD  scoreboard bit of the register addressed by each read port.
- i_wr0_en  in  1  write port 0 enable.
- i_wr0_addr  in  AW  write port 0 address.
- i_wr0_data  in  XLEN  write port 0 data.
- i_wr1_en  in  1  write port 1 enable.
- i_wr1_addr  in  AW  write port 1 address.
- i_wr1_data  in  XLEN  write port 1 data.
- i_sb_set_en  in  1  mark a register pending.
- i_sb_set_addr  in  AW  register to mark pending.
- i_clr_req  in  1  start the sweep-clear; single-cycle pulse.
- o_clr_busy  out  1  sweep-clear in progress.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - all NREG registers = 0;
  - scoreboard = 0;
  - FSM = IDLE, sweep index = 0;
  - o_clr_busy = 0.
  - Reset asserted mid-sweep aborts the sweep and gives the same final state.
- Reads:
  - Purely combinational from the array.
  - o_rs_data = 0 when addr==0 and ZERO_REG=1.
  - No write-to-read forwarding unless REGFILE_BYPASS_EN is defined.
- Writes:
  - A write takes effect at posedge; data is visible on reads in the next cycle.
  - Both ports enabled to the same address: port 1 wins.
  - Writes to reg 0 with ZERO_REG=1 are dropped.
- Scoreboard:
  - An enabled write to reg r clears busy[r] at posedge.
  - i_sb_set_en sets busy[i_sb_set_addr].
  - Set and write to the same r in the same cycle: set wins (new producer), busy[r]=1, data still written.
  - o_rs_busy is combinational from the current scoreboard (no bypass of same-cycle set/clear).
- Sweep FSM:
  - IDLE: on i_clr_req -> CLEAR; index = 0; scoreboard cleared entirely that edge.
  - CLEAR:
    - each cycle writes 0 to reg[index], index += 1;
    - after writing NREG-1 -> IDLE; total NREG cycles with o_clr_busy=1, starting the cycle after the request;
    - write ports and i_sb_set_en are ignored while o_clr_busy=1;
    - i_clr_req is ignored while in CLEAR (no restart);
    - reads remain live and return partially cleared contents.
  - Index wraps naturally at NREG; it is compared against NREG-1, never overflows.
- i_clr_req together with writes in the IDLE cycle: the writes commit, the scoreboard clear overrides any i_sb_set_en, and the sweep then zeroes everything.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data when its address matches an enabled write port that is not suppressed (port 1 over port 0; never for reg 0 with ZERO_REG=1; never while o_clr_busy=1).
  - o_rs_busy reads 0 when a non-suppressed write to that address is in flight and no same-cycle set targets it.
- Not defined:
  - Reads return only the stored array value and stored scoreboard bit; pure combinational mux, no added logic.

Test Plan:
- Reset then read all regs -> every o_rs_data = 0, o_rs_busy = 0, o_clr_busy = 0.
- wr0 (addr 5, 0xDEADBEEF) and wr1 (addr 5, 0x12345678) same cycle; next cycle read 5 -> 0x12345678.
- Write 0xFFFFFFFF to reg 0 (ZERO_REG=1); set sb on 0 -> read 0 = 0, busy = 0.
- sb_set 7; next cycle busy=1; write 7 = 0xA5 -> next cycle busy=0, data 0xA5. Same-cycle set+write on 7 -> busy stays 1.
- Load regs 1..31 = index; pulse i_clr_req -> o_clr_busy high exactly 32 cycles. A write to 3 mid-sweep is dropped; afterwards all regs 0. Reset asserted at sweep cycle 10 -> o_clr_busy=0 next cycle, all regs 0.
- With REGFILE_BYPASS_EN: write 9 = 0x55 while reading 9 same cycle -> o_rs_data = 0x55 that cycle. Without it -> old value that cycle, 0x55 next.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read ports, two prioritised write ports, per-register
// scoreboard and a sequential sweep-clear engine. Optional forwarding under REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NRD*AW-1:0]   i_rs_addr,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]      o_rs_busy,
    input  logic                i_wr0_en,
    input  logic [AW-1:0]       i_wr0_addr,
    input  logic [XLEN-1:0]     i_wr0_data,
    input  logic                i_wr1_en,
    input  logic [AW-1:0]       i_wr1_addr,
    input  logic [XLEN-1:0]     i_wr1_data,
    input  logic                i_sb_set_en,
    input  logic [AW-1:0]       i_sb_set_addr,
    input  logic                i_clr_req,
    output logic                o_clr_busy
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                      r_state, w_state_nxt;
    logic [AW-1:0]               r_idx, w_idx_nxt;
    logic [NREG-1:0][XLEN-1:0]   r_regs;
    logic [NREG-1:0]             r_busy;

    logic w_clr_act, w_flush, w_wr0, w_wr1, w_sbs;

    assign w_clr_act  = (r_state == S_CLEAR);
    assign w_flush    = (r_state == S_IDLE) && i_clr_req;
    assign w_wr0      = i_wr0_en    && !w_clr_act;
    assign w_wr1      = i_wr1_en    && !w_clr_act;
    assign w_sbs      = i_sb_set_en && !w_clr_act;
    assign o_clr_busy = w_clr_act;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_idx_nxt = r_idx + AW'(1);
                if (r_idx == AW'(NREG - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Port 1 beats port 0; a scoreboard set beats the clear implied by a write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (ZERO_REG != 0 && r == 0) begin
                    r_regs[r] <= '0;
                    r_busy[r] <= 1'b0;
                end else begin
                    if (w_clr_act) begin
                        if (r_idx == AW'(r)) r_regs[r] <= '0;
                    end else if (w_wr1 && i_wr1_addr == AW'(r)) begin
                        r_regs[r] <= i_wr1_data;
                    end else if (w_wr0 && i_wr0_addr == AW'(r)) begin
                        r_regs[r] <= i_wr0_data;
                    end

                    if (w_flush) begin
                        r_busy[r] <= 1'b0;
                    end else if (w_sbs && i_sb_set_addr == AW'(r)) begin
                        r_busy[r] <= 1'b1;
                    end else if ((w_wr1 && i_wr1_addr == AW'(r)) ||
                                 (w_wr0 && i_wr0_addr == AW'(r))) begin
                        r_busy[r] <= 1'b0;
                    end
                end
            end
        end
    end

    logic [NRD-1:0][XLEN-1:0] w_rd_data;
    assign o_rs_data = w_rd_data;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_zero;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = i_rs_addr[k*AW +: AW];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (!w_zero) begin
                if (w_wr1 && i_wr1_addr == w_addr)      w_data = i_wr1_data;
                else if (w_wr0 && i_wr0_addr == w_addr) w_data = i_wr0_data;
                if (((w_wr1 && i_wr1_addr == w_addr) || (w_wr0 && i_wr0_addr == w_addr)) &&
                    !(w_sbs && i_sb_set_addr == w_addr))
                    w_busy = 1'b0;
            end
`endif
            if (w_zero) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign w_rd_data[k] = w_data;
        assign o_rs_busy[k] = w_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (XLEN=32, NREG=32, NRD=2, ZERO_REG=1).
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic [NRD*AW-1:0]   i_rs_addr;
    logic [NRD*XLEN-1:0] o_rs_data;
    logic [NRD-1:0]      o_rs_busy;
    logic                i_wr0_en, i_wr1_en, i_sb_set_en, i_clr_req;
    logic [AW-1:0]       i_wr0_addr, i_wr1_addr, i_sb_set_addr;
    logic [XLEN-1:0]     i_wr0_data, i_wr1_data;
    logic                o_clr_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rs_addr(i_rs_addr), .o_rs_data(o_rs_data), .o_rs_busy(o_rs_busy),
        .i_wr0_en(i_wr0_en), .i_wr0_addr(i_wr0_addr), .i_wr0_data(i_wr0_data),
        .i_wr1_en(i_wr1_en), .i_wr1_addr(i_wr1_addr), .i_wr1_data(i_wr1_data),
        .i_sb_set_en(i_sb_set_en), .i_sb_set_addr(i_sb_set_addr),
        .i_clr_req(i_clr_req), .o_clr_busy(o_clr_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle_in();
        i_wr0_en = 0; i_wr1_en = 0; i_sb_set_en = 0; i_clr_req = 0;
    endtask

    task automatic rd(input int a0, input int a1);
        i_rs_addr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic wr0(input int a, input logic [31:0] d);
        i_wr0_en = 1; i_wr0_addr = AW'(a); i_wr0_data = d;
    endtask

    task automatic wr1(input int a, input logic [31:0] d);
        i_wr1_en = 1; i_wr1_addr = AW'(a); i_wr1_data = d;
    endtask

    task automatic sbset(input int a);
        i_sb_set_en = 1; i_sb_set_addr = AW'(a);
    endtask

    initial begin
        idle_in();
        i_wr0_addr = '0; i_wr0_data = '0; i_wr1_addr = '0; i_wr1_data = '0;
        i_sb_set_addr = '0; i_rs_addr = '0;
        i_rst_n = 0;
        tick(); tick();
        i_rst_n = 1;
        #1;
        chk("rst_clr_busy", {31'd0, o_clr_busy}, 32'd0);
        for (int r = 0; r < NREG; r += 2) begin
            rd(r, r + 1);
            chk($sformatf("rst_data_%0d", r),     o_rs_data[31:0],  32'd0);
            chk($sformatf("rst_data_%0d", r + 1), o_rs_data[63:32], 32'd0);
            chk($sformatf("rst_busy_%0d_%0d", r, r + 1), {30'd0, o_rs_busy}, 32'd0);
        end

        // same-address dual write: port 1 wins
        wr0(5, 32'hDEADBEEF); wr1(5, 32'h12345678);
        tick(); idle_in();
        rd(5, 0);
        chk("wr_prio_5", o_rs_data[31:0], 32'h12345678);

        // distinct addresses on both ports
        wr0(10, 32'h0000AAAA); wr1(11, 32'h0000BBBB);
        tick(); idle_in();
        rd(10, 11);
        chk("wr0_10", o_rs_data[31:0],  32'h0000AAAA);
        chk("wr1_11", o_rs_data[63:32], 32'h0000BBBB);

        // register 0 hardwired
        wr0(0, 32'hFFFFFFFF); sbset(0);
        tick(); idle_in();
        rd(0, 5);
        chk("zero_data", o_rs_data[31:0], 32'd0);
        chk("zero_busy", {31'd0, o_rs_busy[0]}, 32'd0);
        chk("r5_kept", o_rs_data[63:32], 32'h12345678);

        // scoreboard
        sbset(7);
        tick(); idle_in();
        rd(7, 6);
        chk("sb7_set", {30'd0, o_rs_busy}, 32'd1);
        wr0(7, 32'h000000A5);
        tick(); idle_in();
        rd(7, 6);
        chk("sb7_clr_busy", {31'd0, o_rs_busy[0]}, 32'd0);
        chk("sb7_clr_data", o_rs_data[31:0], 32'h000000A5);
        sbset(7); wr1(7, 32'h0000005A);
        tick(); idle_in();
        rd(7, 6);
        chk("sb7_setwins_busy", {31'd0, o_rs_busy[0]}, 32'd1);
        chk("sb7_setwins_data", o_rs_data[31:0], 32'h0000005A);

        // load regs 1..31 = index
        for (int r = 1; r < NREG; r++) begin
            wr0(r, 32'(r));
            tick();
        end
        idle_in();
        sbset(12);
        tick(); idle_in();
        rd(12, 4);
        chk("sb12_pre", {31'd0, o_rs_busy[0]}, 32'd1);

        // clear request with a write and an sb set in the same cycle
        i_clr_req = 1; wr0(4, 32'h00000044); sbset(12);
        tick(); idle_in();
        rd(12, 4);
        chk("clr_start_busy", {31'd0, o_clr_busy}, 32'd1);
        chk("clr_sb12_flush", {31'd0, o_rs_busy[0]}, 32'd0);
        chk("clr_wr4_commit", o_rs_data[63:32], 32'h00000044);

        cnt = 0;
        while (o_clr_busy === 1'b1 && cnt < 100) begin
            idle_in();
            if (cnt == 5)  i_clr_req = 1;
            if (cnt == 10) begin wr0(3, 32'h00000333); sbset(20); end
            if (cnt == 16) begin
                rd(15, 16);
                chk("sweep_partial_15", o_rs_data[31:0],  32'd0);
                chk("sweep_partial_16", o_rs_data[63:32], 32'd16);
            end
            cnt++;
            tick();
        end
        idle_in();
        #1;
        chk("sweep_cycles", 32'(cnt), 32'd32);
        chk("sweep_done", {31'd0, o_clr_busy}, 32'd0);
        for (int r = 0; r < NREG; r += 2) begin
            rd(r, r + 1);
            chk($sformatf("sweep_data_%0d", r),     o_rs_data[31:0],  32'd0);
            chk($sformatf("sweep_data_%0d", r + 1), o_rs_data[63:32], 32'd0);
        end
        rd(20, 3);
        chk("sweep_sb20_ignored", {30'd0, o_rs_busy}, 32'd0);

        // reset in the middle of a sweep
        wr0(20, 32'h00002020); wr1(31, 32'h00003131);
        tick(); idle_in();
        i_clr_req = 1;
        tick(); idle_in();
        for (int c = 0; c < 10; c++) tick();
        i_rst_n = 0;
        tick();
        i_rst_n = 1;
        #1;
        chk("rst_mid_clr_busy", {31'd0, o_clr_busy}, 32'd0);
        rd(20, 31);
        chk("rst_mid_20", o_rs_data[31:0],  32'd0);
        chk("rst_mid_31", o_rs_data[63:32], 32'd0);

        // same-cycle write/read of register 9
        sbset(9);
        tick(); idle_in();
        wr0(9, 32'h00000055);
        rd(9, 0);
`ifdef REGFILE_BYPASS_EN
        chk("byp_data_9", o_rs_data[31:0], 32'h00000055);
        chk("byp_busy_9", {31'd0, o_rs_busy[0]}, 32'd0);
`else
        chk("nobyp_data_9", o_rs_data[31:0], 32'd0);
        chk("nobyp_busy_9", {31'd0, o_rs_busy[0]}, 32'd1);
`endif
        tick(); idle_in();
        #1;
        chk("after_data_9", o_rs_data[31:0], 32'h00000055);
        chk("after_busy_9", {31'd0, o_rs_busy[0]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
